// File: rtl/gb_mem_pkg.sv
// Shared constants and DMA state type for the Game Boy style memory subsystem.
package gb_mem_pkg;

   localparam int unsigned     ADDR_W_DEF       = 16;
   localparam int unsigned     DMA_LEN_DEF      = 160;
   localparam logic [15:0]     DMA_REG_ADDR_DEF = 16'hFF46;
   localparam logic [15:0]     DST_BASE_DEF     = 16'hFE00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      READ  = 2'd2,
      WRITE = 2'd3
   } dma_state_t;

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: start register, FSM, byte index and data latch.
// Optional restart on register write while busy is enabled by DMA_RESTART_EN.
module oam_dma_engine
   import gb_mem_pkg::*;
#(
   parameter int unsigned       ADDR_W       = ADDR_W_DEF,
   parameter int unsigned       DMA_LEN      = DMA_LEN_DEF,
   parameter logic [ADDR_W-1:0] DMA_REG_ADDR = ADDR_W'(DMA_REG_ADDR_DEF),
   parameter logic [ADDR_W-1:0] DST_BASE     = ADDR_W'(DST_BASE_DEF)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_data_write,
   input  logic              cpu_do_write,
   input  logic [7:0]        mem_data_read,
   output logic              reg_sel_c,
   output logic [7:0]        dma_reg,
   output logic [ADDR_W-1:0] eng_addr_c,
   output logic [7:0]        eng_data,
   output logic              eng_we_c,
   output logic              dma_active
);

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

   dma_state_t state_q, state_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] latch_q, latch_d;
   logic [7:0] dma_reg_d;
   logic       reg_wr;

   assign reg_sel_c = (cpu_addr == DMA_REG_ADDR);
   assign reg_wr    = reg_sel_c & cpu_do_write;
   assign eng_data  = latch_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         idx_q      <= 8'h00;
         latch_q    <= 8'h00;
         dma_reg    <= 8'h00;
         dma_active <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         latch_q    <= latch_d;
         dma_reg    <= dma_reg_d;
         dma_active <= (state_d != IDLE);
      end
   end

   // Next state, counters and engine side of the memory port
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      latch_d    = latch_q;
      dma_reg_d  = dma_reg;
      eng_addr_c = DST_BASE + ADDR_W'(idx_q);
      eng_we_c   = 1'b0;

      case (state_q)
         IDLE: begin
            if (reg_wr) begin
               dma_reg_d = cpu_data_write;
               state_d   = START;
            end
         end
         START: begin
            state_d = READ;
         end
         READ: begin
            eng_addr_c = ADDR_W'({dma_reg, 8'h00}) + ADDR_W'(idx_q);
            latch_d    = mem_data_read;
            state_d    = WRITE;
         end
         WRITE: begin
            eng_we_c = 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d   = 8'h00;
               state_d = IDLE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = READ;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef DMA_RESTART_EN
      // A register write while busy (final WRITE included) restarts from the new page
      if (reg_wr && (state_q != IDLE)) begin
         dma_reg_d = cpu_data_write;
         idx_d     = 8'h00;
         state_d   = START;
      end
`endif
   end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Memory port arbiter between the CPU and the OAM DMA engine (see oam_dma_engine).
// Build option: DMA_RESTART_EN allows a busy engine to be restarted by a register write.
module oam_dma_arbiter
   import gb_mem_pkg::*;
#(
   parameter int unsigned       ADDR_W       = ADDR_W_DEF,
   parameter int unsigned       DMA_LEN      = DMA_LEN_DEF,
   parameter logic [ADDR_W-1:0] DMA_REG_ADDR = ADDR_W'(DMA_REG_ADDR_DEF),
   parameter logic [ADDR_W-1:0] DST_BASE     = ADDR_W'(DST_BASE_DEF)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_data_write,
   input  logic              cpu_do_write,
   output logic [7:0]        cpu_data_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data_write,
   output logic              mem_do_write,
   input  logic [7:0]        mem_data_read,
   output logic              dma_active
);

   logic              reg_sel_c;
   logic [7:0]        dma_reg;
   logic [ADDR_W-1:0] eng_addr_c;
   logic [7:0]        eng_data;
   logic              eng_we_c;

   oam_dma_engine #(
      .ADDR_W       (ADDR_W),
      .DMA_LEN      (DMA_LEN),
      .DMA_REG_ADDR (DMA_REG_ADDR),
      .DST_BASE     (DST_BASE)
   ) u_engine (
      .clk            (clk),
      .reset_n        (reset_n),
      .cpu_addr       (cpu_addr),
      .cpu_data_write (cpu_data_write),
      .cpu_do_write   (cpu_do_write),
      .mem_data_read  (mem_data_read),
      .reg_sel_c      (reg_sel_c),
      .dma_reg        (dma_reg),
      .eng_addr_c     (eng_addr_c),
      .eng_data       (eng_data),
      .eng_we_c       (eng_we_c),
      .dma_active     (dma_active)
   );

   // Memory port ownership; register writes never reach memory
   always_comb begin
      mem_addr       = cpu_addr;
      mem_data_write = cpu_data_write;
      mem_do_write   = cpu_do_write & ~reg_sel_c;
      if (dma_active) begin
         mem_addr       = eng_addr_c;
         mem_data_write = eng_data;
         mem_do_write   = eng_we_c;
      end
   end

   // CPU read data: register always visible, memory hidden while DMA runs
   always_comb begin
      cpu_data_read = mem_data_read;
      if (reg_sel_c) begin
         cpu_data_read = dma_reg;
      end else if (dma_active) begin
         cpu_data_read = 8'hFF;
      end
   end

endmodule
